// File: rtl/ee354_gcd_param.sv
// ee354_gcd_param: parametrised, clock-enabled GCD engine.
// Subtract-only or binary (Stein) reduction chosen per run, Start/Ack
// handshake, one-hot registered state outputs and a saturating per-run
// cycle counter covering the q_Sub and q_Mult states.
module ee354_gcd_param #(
  parameter int WIDTH = 8,
  parameter int I_W   = $clog2(WIDTH) + 1,
  parameter int CYC_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CEN,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AB_GCD,
  output logic [I_W-1:0]   i_count,
  output logic [CYC_W-1:0] Cycles,
  output logic             q_I,
  output logic             q_Sub,
  output logic             q_Mult,
  output logic             q_Done
);

  typedef enum logic [3:0] {
    S_I    = 4'b0001,
    S_SUB  = 4'b0010,
    S_MULT = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  localparam logic [I_W-1:0]   I_ONE   = I_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] gcd_q;
  logic [I_W-1:0]   i_q;
  logic [CYC_W-1:0] cyc_q;
  logic             mode_q;

  // Cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_ONE;
  endfunction

  // Whole engine: state, operands, result, power-of-two count and cycle count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_I;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      i_q     <= '0;
      cyc_q   <= '0;
      mode_q  <= 1'b0;
    end else if (CEN) begin
      unique case (state_q)
        S_I: begin
          a_q <= Ain;
          b_q <= Bin;
          if (Start) begin
            i_q     <= '0;
            cyc_q   <= '0;
            mode_q  <= Mode;
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          cyc_q <= sat_inc(cyc_q);
          // Equal operands (including 0,0) and zero operands terminate first;
          // the guarded compare keeps the subtraction from underflowing.
          if (a_q == b_q) begin
            gcd_q   <= a_q;
            state_q <= S_MULT;
          end else if (a_q == '0) begin
            gcd_q   <= b_q;
            state_q <= S_MULT;
          end else if (b_q == '0) begin
            gcd_q   <= a_q;
            state_q <= S_MULT;
          end else if (mode_q && !a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            i_q <= i_q + I_ONE;
          end else if (mode_q && !a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (mode_q && !b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        S_MULT: begin
          cyc_q <= sat_inc(cyc_q);
          // Restore the common factors of two removed during reduction.
          if (i_q == '0) begin
            state_q <= S_DONE;
          end else begin
            gcd_q <= gcd_q << 1;
            i_q   <= i_q - I_ONE;
          end
        end
        S_DONE: begin
          if (Ack) state_q <= S_I;
        end
        default: state_q <= S_I;
      endcase
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign AB_GCD  = gcd_q;
  assign i_count = i_q;
  assign Cycles  = cyc_q;
  assign q_I     = (state_q == S_I);
  assign q_Sub   = (state_q == S_SUB);
  assign q_Mult  = (state_q == S_MULT);
  assign q_Done  = (state_q == S_DONE);

endmodule

// File: tb/tb_ee354_gcd_param.sv
// Testbench for ee354_gcd_param: an 8-bit and a 16-bit instance driven by
// directed runs; a behavioural model predicts result and cycle count.
module tb_ee354_gcd_param;

  localparam logic [72:0] RST_VEC = {69'b0, 4'b1000};

  logic Clk = 1'b0;
  logic rst_n, cen, mode;
  logic st8, ak8, st16, ak16;
  logic [7:0]  ain8, bin8, a8, b8, g8;
  logic [3:0]  i8;
  logic [15:0] cyc8;
  logic qi8, qs8, qm8, qd8;
  logic [15:0] ain16, bin16, a16, b16, g16;
  logic [4:0]  i16;
  logic [15:0] cyc16;
  logic qi16, qs16, qm16, qd16;

  logic        sel;
  logic [15:0] cur_a, cur_b, cur_g, cur_cyc;
  logic [4:0]  cur_i;
  logic        cur_qi, cur_qs, cur_qm, cur_done;
  logic [72:0] cur_all;

  int n_cmp = 0;
  int n_fail = 0;
  int run_id = 0;
  int checked_id = 0;
  int exp_g, exp_cyc, exp_euc;
  int last_g, last_cyc;

  ee354_gcd_param #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(rst_n), .CEN(cen), .Start(st8), .Ack(ak8), .Mode(mode),
    .Ain(ain8), .Bin(bin8), .A(a8), .B(b8), .AB_GCD(g8), .i_count(i8),
    .Cycles(cyc8), .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8));

  ee354_gcd_param #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(rst_n), .CEN(cen), .Start(st16), .Ack(ak16), .Mode(mode),
    .Ain(ain16), .Bin(bin16), .A(a16), .B(b16), .AB_GCD(g16), .i_count(i16),
    .Cycles(cyc16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16));

  initial forever #5 Clk = ~Clk;

  always_comb begin
    cur_a    = sel ? a16   : {8'h00, a8};
    cur_b    = sel ? b16   : {8'h00, b8};
    cur_g    = sel ? g16   : {8'h00, g8};
    cur_cyc  = sel ? cyc16 : cyc8;
    cur_i    = sel ? i16   : {1'b0, i8};
    cur_qi   = sel ? qi16  : qi8;
    cur_qs   = sel ? qs16  : qs8;
    cur_qm   = sel ? qm16  : qm8;
    cur_done = sel ? qd16  : qd8;
    cur_all  = {cur_a, cur_b, cur_g, cur_i, cur_cyc, cur_qi, cur_qs, cur_qm, cur_done};
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Plain Euclid by remainder, independent of the engine's algorithm.
  function automatic int euclid(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Result and run length from the reduction rules: one rule per q_Sub
  // clock, then one q_Mult clock per removed factor of two plus one.
  function automatic void model(input int a, input int b, input bit m,
                                output int g, output int cyc);
    int k = 0;
    int steps = 0;
    g = 0;
    forever begin
      steps++;
      if (a == b) begin g = a; break; end
      else if (a == 0) begin g = b; break; end
      else if (b == 0) begin g = a; break; end
      else if (m && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; k++; end
      else if (m && a % 2 == 0) a = a / 2;
      else if (m && b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    g = g * (2 ** k);
    cyc = steps + k + 1;
    if (cyc > 65535) cyc = 65535;
  endfunction

  task automatic run(input bit s, input int a, input int b, input bit m, input bit both,
                     input bit trace, input int stall_at, input int rst_at);
    int g, cyc, n;
    logic [72:0] snap;
    bit aborted;
    model(a, b, m, g, cyc);
    exp_g = g; exp_cyc = cyc; exp_euc = euclid(a, b);
    run_id++;
    aborted = 0;
    @(negedge Clk);
    sel = s; mode = m;
    if (s) begin ain16 = 16'(a); bin16 = 16'(b); st16 = 1; ak16 = both; end
    else   begin ain8  = 8'(a);  bin8  = 8'(b);  st8  = 1; ak8  = both; end
    @(negedge Clk);
    st8 = 0; st16 = 0; ak8 = 0; ak16 = 0;
    ain8 = 8'($urandom); bin8 = 8'($urandom);
    ain16 = 16'($urandom); bin16 = 16'($urandom); mode = ~m;
    n = 0;
    while (!cur_done && n < 600) begin
      if (trace) begin
        if (n == 0) begin chk("trace0_A", cur_a, 36); chk("trace0_B", cur_b, 24); end
        if (n == 1) begin chk("trace1_A", cur_a, 12); chk("trace1_B", cur_b, 24); end
        if (n == 2) begin chk("trace2_A", cur_a, 12); chk("trace2_B", cur_b, 12); end
      end
      if (n == stall_at) begin
        cen = 0;
        snap = cur_all;
        repeat (7) begin
          @(negedge Clk);
          chk("stall_hold", cur_all, snap);
        end
        cen = 1;
      end
      if (n == rst_at) begin
        chk("in_mult_before_reset", cur_qm, 1);
        #3 rst_n = 0;
        #1 chk("async_reset", cur_all, RST_VEC);
        @(negedge Clk);
        rst_n = 1;
        aborted = 1;
        break;
      end
      @(negedge Clk);
      n++;
    end
    if (!aborted) begin
      chk("done_reached", cur_done, 1);
      if (cur_done) begin
        chk("latency", n, cyc);
        last_g = cur_g; last_cyc = cur_cyc;
        if (s) begin ak16 = 1; st16 = both; end
        else   begin ak8  = 1; st8  = both; end
        @(negedge Clk);
        ak8 = 0; ak16 = 0; st8 = 0; st16 = 0;
        chk("ack_to_idle", cur_qi, 1);
      end
    end
  endtask

  initial begin
    rst_n = 0; cen = 1; mode = 0; sel = 0;
    st8 = 0; ak8 = 0; st16 = 0; ak16 = 0;
    ain8 = 0; bin8 = 0; ain16 = 0; bin16 = 0;
    last_g = 0; last_cyc = 0;
    exp_g = 0; exp_cyc = 0; exp_euc = 0;
    fork
      begin
        int g, c;
        repeat (2) @(negedge Clk);
        chk("reset_state8", cur_all, RST_VEC);
        chk("reset_state16", {a16, b16, g16, i16, cyc16, qi16, qs16, qm16, qd16}, RST_VEC);
        rst_n = 1;

        model(36, 24, 1, g, c);
        chk("pin_model_g", g, 12);
        chk("pin_model_cyc", c, 9);
        model(36, 24, 0, g, c);
        chk("pin_model_cyc_m0", c, 4);

        run(0, 36, 24, 1, 0, 0, -1, -1);
        chk("stein_gcd", last_g, 12);  chk("stein_cyc", last_cyc, 9);
        run(0, 36, 24, 0, 1, 1, -1, -1);
        chk("sub_gcd", last_g, 12);    chk("sub_cyc", last_cyc, 4);
        run(0, 0, 45, 1, 0, 0, -1, -1);
        chk("zeroA_gcd", last_g, 45);  chk("zeroA_cyc", last_cyc, 2);
        run(0, 0, 0, 0, 0, 0, -1, -1);
        chk("zero0_gcd", last_g, 0);   chk("zero0_cyc", last_cyc, 2);
        run(0, 36, 24, 1, 0, 0, 3, -1);
        chk("stall_gcd", last_g, 12);  chk("stall_cyc", last_cyc, 9);
        run(0, 36, 24, 1, 0, 0, -1, 7);
        run(0, 48, 18, 1, 0, 0, -1, -1);
        chk("after_rst_gcd", last_g, 6); chk("after_rst_cyc", last_cyc, 9);
        run(0, 128, 64, 1, 0, 0, -1, -1);
        chk("pow2_gcd", last_g, 64);
        run(0, 255, 254, 0, 0, 0, -1, -1);
        chk("coprime_gcd", last_g, 1);
        run(1, 65535, 255, 1, 0, 0, -1, -1);
        chk("w16_gcd", last_g, 255);
        for (int a = 2; a < 64; a += 3)
          for (int b = 2; b < 64; b += 3)
            for (int m = 0; m < 2; m++)
              run(1, a, b, m[0], 0, 0, -1, -1);
        repeat (2) @(negedge Clk);
      end
      begin
        forever begin
          @(negedge Clk);
          chk("onehot8", 128'($countones({qi8, qs8, qm8, qd8})), 1);
          chk("onehot16", 128'($countones({qi16, qs16, qm16, qd16})), 1);
          if (cur_done && checked_id != run_id) begin
            checked_id = run_id;
            chk("gcd_model", cur_g, exp_g);
            chk("gcd_euclid", cur_g, exp_euc);
            chk("cycles_model", cur_cyc, exp_cyc);
            chk("i_count_done", cur_i, 0);
          end
        end
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
